load_store_fsm_p: RTL and testbench
===================================

Name: load_store_fsm_p

Overview:
- Parametrised successor to the single-width LOAD controller.
- Sequences the LOAD and STORE micro-operations between register file, MAR/MDR and memory.
- Waits on the MFC (memory-function-complete) handshake, optionally bounded by a timeout.
- Sits between the instruction decoder (start/opCode/para1/para2) and the datapath control lines. Address width, register count and opcode encodings are generic.

Parameters:
- ADDR_W, 16: width of address output.
- PARA_W, 6: width of para1/para2; must be <= ADDR_W.
- NUM_REGS, 6: register count; width of the one-hot regIn/regOut.
- OP_LOAD, 4'b1011: LOAD opcode.
- OP_STORE, 4'b1100: STORE opcode.
- MFC_TIMEOUT, 15: maximum MEM-state cycles waiting for MFC; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  decoder requests operation; sampled only in IDLE
- opCode  in  4  operation select
- para1  in  PARA_W  register index (LOAD destination / STORE source)
- para2  in  PARA_W  memory address, zero-extended to ADDR_W
- MFC  in  1  memory-function-complete; sampled only in MEM
- address  out  ADDR_W  address to MAR (driven, no tristate)
- marIn  out  1  MAR load enable
- MemEN  out  1  memory enable
- marOut  out  1  MAR drives memory address
- RW  out  1  1=read, 0=write; valid while MemEN=1
- readFromMem  out  1  MDR captures memory data
- outToBus  out  1  MDR drives bus
- readFromBus  out  1  MDR captures bus
- outToMem  out  1  MDR drives memory
- regIn  out  NUM_REGS  one-hot register write select
- regOut  out  NUM_REGS  one-hot register read select
- incr  out  1  PC increment
- fetch  out  1  request next instruction fetch
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  one-cycle pulse on MFC timeout

Behaviour:
- Architecture
  - Moore FSM. All outputs decode from the state register plus latched operands only, with no combinational path from inputs.
  - Any output not listed for a state is 0.
- States: IDLE, MAR, BUS, MEM, RDMEM, DONE, ERR.
- Operand capture
  - In IDLE, start=1 with opCode==OP_LOAD or OP_STORE latches opCode, para1 and para2, then moves to MAR.
  - start with any other opCode is ignored; stay in IDLE.
- MAR
  - marIn=1; address = zero-extended latched para2.
  - Next state: LOAD goes to MEM, STORE goes to BUS.
  - address holds the latched value in all non-IDLE states and 0 in IDLE.
- BUS (STORE only): regOut = onehot(para1), readFromBus=1; next state MEM.
- MEM
  - Outputs: MemEN=1, marOut=1, RW=1 for LOAD / 0 for STORE, outToMem=1 for STORE.
  - MFC=1 goes to RDMEM (LOAD) or DONE (STORE).
  - The cycle counter clears on MEM entry.
- RDMEM (LOAD only): readFromMem=1, outToBus=1, regIn = onehot(para1); next state DONE.
- DONE: fetch=1, incr=1; next state IDLE.
- ERR: timeout_err=1; next state IDLE. No fetch/incr is issued.
- One-hot decode: para1 >= NUM_REGS yields an all-zero select. The operation otherwise completes normally.
- Latency: LOAD with MFC high in the first MEM cycle is MAR, MEM, RDMEM, DONE = 4 cycles after the start edge. STORE is MAR, BUS, MEM, DONE = 4 cycles.
- busy = (state != IDLE).
- Reset
  - All outputs 0, state IDLE, counter 0, latched operands 0.
  - Reset mid-operation aborts at the next edge with no fetch/incr/timeout_err.
  - Reset overrides start.
- Simultaneous events
  - MFC high on the same cycle the timeout expires: MFC wins.
  - start while busy is ignored and not queued.

Optional Feature:
- Macro: LSFSM_MFC_TIMEOUT_EN.
- Defined
  - MEM counts cycles with MFC low.
  - If MFC is still low in the MFC_TIMEOUT-th MEM cycle, the next state is ERR. MEM lasts exactly MFC_TIMEOUT cycles, then ERR for 1 cycle.
- Undefined
  - MEM waits indefinitely for MFC.
  - Neither the counter nor the ERR state is synthesised; timeout_err is tied 0.

Test Plan:
- LOAD, first MEM cycle: reset 2 cycles; opCode=4'b1011, para1=3, para2=6'h2A, start 1 cycle, MFC=1 in first MEM cycle.
  - Expect marIn with address=16'h002A, then MemEN/marOut/RW=1.
  - Then readFromMem/outToBus/regIn=6'b001000, then fetch/incr; busy high for exactly 4 cycles.
- STORE, delayed MFC: opCode=4'b1100, para1=0, para2=6'h3F, MFC asserted on 3rd MEM cycle.
  - Expect BUS with regOut=6'b000001/readFromBus.
  - MEM holds 3 cycles with RW=0/outToMem=1, then DONE.
- Illegal opcode and busy start: opCode=4'b0000 with start gives no state change and busy=0. start pulsed during an active LOAD is ignored; only one DONE occurs.
- Timeout (macro defined, MFC_TIMEOUT=4): LOAD with MFC held 0.
  - Expect MEM for exactly 4 cycles, then timeout_err=1 for 1 cycle, no fetch, return to IDLE.
  - Repeat with MFC=1 in the 4th MEM cycle: expect RDMEM, no error.
- Reset mid-operation: assert reset during MEM of a STORE. Next cycle all outputs are 0 and busy=0; no fetch/incr.
- Out-of-range index: LOAD with para1=7 (NUM_REGS=6) gives regIn=0 in RDMEM; DONE still issues fetch/incr.

Source files
------------

// File: rtl/load_store_fsm_p.sv
// ---------------------------------------------------------------------------
// load_store_fsm_p
//
// Purpose:
//   Moore controller that sequences LOAD and STORE micro-operations between
//   the register file, MAR/MDR and memory. It waits in MEM for the
//   memory-function-complete (MFC) handshake.
//
// Optional feature (macro LSFSM_MFC_TIMEOUT_EN):
//   When the macro is defined, the wait in MEM is bounded to MFC_TIMEOUT
//   cycles. On expiry the FSM goes to ERR for one cycle and pulses
//   timeout_err. When the macro is undefined, MEM waits indefinitely. In that
//   build no counter or ERR logic exists, and timeout_err is tied to 0.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   start, opCode              decoder request and opcode (sampled in IDLE only)
//   para1                      register index (LOAD destination / STORE source)
//   para2                      memory address, zero-extended onto address
//   MFC                        memory-function-complete (sampled in MEM only)
//   address                    latched para2 while busy, 0 in IDLE
//   marIn, MemEN, marOut, RW   MAR / memory control
//   readFromMem, outToBus,
//   readFromBus, outToMem      MDR control
//   regIn, regOut              one-hot register write / read select
//   incr, fetch                PC increment and next-fetch request (DONE)
//   busy                       high in every state except IDLE
//   timeout_err                one-cycle pulse when the MFC wait times out
// ---------------------------------------------------------------------------
module load_store_fsm_p #(
   parameter int          ADDR_W      = 16,
   parameter int          PARA_W      = 6,
   parameter int          NUM_REGS    = 6,
   parameter logic [3:0]  OP_LOAD     = 4'b1011,
   parameter logic [3:0]  OP_STORE    = 4'b1100,
   parameter int          MFC_TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [3:0]          opCode,
   input  logic [PARA_W-1:0]   para1,
   input  logic [PARA_W-1:0]   para2,
   input  logic                MFC,
   output logic [ADDR_W-1:0]   address,
   output logic                marIn,
   output logic                MemEN,
   output logic                marOut,
   output logic                RW,
   output logic                readFromMem,
   output logic                outToBus,
   output logic                readFromBus,
   output logic                outToMem,
   output logic [NUM_REGS-1:0] regIn,
   output logic [NUM_REGS-1:0] regOut,
   output logic                incr,
   output logic                fetch,
   output logic                busy,
   output logic                timeout_err
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_MAR   = 3'd1,
      S_BUS   = 3'd2,
      S_MEM   = 3'd3,
      S_RDMEM = 3'd4,
      S_DONE  = 3'd5,
      S_ERR   = 3'd6
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          op_q, op_d;
   logic [PARA_W-1:0]   para1_q, para1_d;
   logic [PARA_W-1:0]   para2_q, para2_d;
   logic                is_load;
   logic [NUM_REGS-1:0] reg_sel;

`ifdef LSFSM_MFC_TIMEOUT_EN
   // The counter holds the 0-based index of the current MEM cycle. It only
   // needs to reach MFC_TIMEOUT-1.
   localparam int CNT_W = (MFC_TIMEOUT > 1) ? $clog2(MFC_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MFC_TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

   // Only LOAD or STORE is ever latched, so "not LOAD" means STORE.
   assign is_load = (op_q == OP_LOAD);

   // One-hot decode of the latched register index. An out-of-range index
   // matches no bit and gives an all-zero select.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_onehot
         assign reg_sel[gi] = (para1_q == PARA_W'(gi));
      end
   endgenerate

   // ------------------------------------------------------------------
   // State and operand registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         para1_q <= '0;
         para2_q <= '0;
`ifdef LSFSM_MFC_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         para1_q <= para1_d;
         para2_q <= para2_d;
`ifdef LSFSM_MFC_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   // ------------------------------------------------------------------
   // Next-state and operand-capture logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      para1_d = para1_q;
      para2_d = para2_q;
`ifdef LSFSM_MFC_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            // Unknown opcodes are dropped. The FSM stays idle.
            if (start && (opCode == OP_LOAD || opCode == OP_STORE)) begin
               op_d    = opCode;
               para1_d = para1;
               para2_d = para2;
               state_d = S_MAR;
            end
         end
         S_MAR: begin
            state_d = is_load ? S_MEM : S_BUS;
`ifdef LSFSM_MFC_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         S_BUS: begin
            state_d = S_MEM;
`ifdef LSFSM_MFC_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         S_MEM: begin
            // MFC is checked first, so it wins over a timeout that expires
            // in the same cycle.
            if (MFC) begin
               state_d = is_load ? S_RDMEM : S_DONE;
            end
`ifdef LSFSM_MFC_TIMEOUT_EN
            else if (cnt_q == CNT_LAST) begin
               state_d = S_ERR;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         S_RDMEM: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
`ifdef LSFSM_MFC_TIMEOUT_EN
         S_ERR:   state_d = S_IDLE;
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Moore output decode: depends on state and latched operands only
   // ------------------------------------------------------------------
   always_comb begin
      address     = '0;
      marIn       = 1'b0;
      MemEN       = 1'b0;
      marOut      = 1'b0;
      RW          = 1'b0;
      readFromMem = 1'b0;
      outToBus    = 1'b0;
      readFromBus = 1'b0;
      outToMem    = 1'b0;
      regIn       = '0;
      regOut      = '0;
      incr        = 1'b0;
      fetch       = 1'b0;
      busy        = (state_q != S_IDLE);
      timeout_err = 1'b0;

      if (state_q != S_IDLE) begin
         address = ADDR_W'(para2_q);
      end

      case (state_q)
         S_MAR: marIn = 1'b1;
         S_BUS: begin
            regOut      = reg_sel;
            readFromBus = 1'b1;
         end
         S_MEM: begin
            MemEN    = 1'b1;
            marOut   = 1'b1;
            RW       = is_load;
            outToMem = ~is_load;
         end
         S_RDMEM: begin
            readFromMem = 1'b1;
            outToBus    = 1'b1;
            regIn       = reg_sel;
         end
         S_DONE: begin
            fetch = 1'b1;
            incr  = 1'b1;
         end
`ifdef LSFSM_MFC_TIMEOUT_EN
         S_ERR: timeout_err = 1'b1;
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_load_store_fsm_p.sv
// ---------------------------------------------------------------------------
// tb_load_store_fsm_p
//
// Self-checking bench for load_store_fsm_p (ADDR_W=16, PARA_W=6, NUM_REGS=6,
// MFC_TIMEOUT=4).
//
// A table of per-cycle vectors covers the LOAD and STORE flows, illegal
// opcodes, start while busy, and an out-of-range register index. Each vector
// holds the inputs for one cycle and the outputs expected in that cycle.
// Hand-written sequences cover reset, reset mid-operation, and the MFC
// timeout. When the macro LSFSM_MFC_TIMEOUT_EN is undefined, the timeout
// sequence instead checks an unbounded MFC wait.
//
// Inputs are driven and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_load_store_fsm_p;

   localparam logic [3:0] OPL = 4'b1011;
   localparam logic [3:0] OPS = 4'b1100;

   // ctrl bit order: marIn MemEN marOut RW readFromMem outToBus readFromBus
   //                 outToMem incr fetch busy timeout_err
   localparam logic [11:0] C_MARIN  = 12'h800;
   localparam logic [11:0] C_MEMEN  = 12'h400;
   localparam logic [11:0] C_MAROUT = 12'h200;
   localparam logic [11:0] C_RW     = 12'h100;
   localparam logic [11:0] C_RDMEM  = 12'h080;
   localparam logic [11:0] C_OUTBUS = 12'h040;
   localparam logic [11:0] C_RDBUS  = 12'h020;
   localparam logic [11:0] C_OUTMEM = 12'h010;
   localparam logic [11:0] C_INCR   = 12'h008;
   localparam logic [11:0] C_FETCH  = 12'h004;
   localparam logic [11:0] C_BUSY   = 12'h002;
   localparam logic [11:0] C_TERR   = 12'h001;

   typedef struct packed {
      logic [15:0] addr;
      logic [5:0]  reg_in;
      logic [5:0]  reg_out;
      logic [11:0] ctrl;
   } out_t;

   typedef struct {
      string      name;
      logic       rst;
      logic       st;
      logic [3:0] op;
      logic [5:0] p1;
      logic [5:0] p2;
      logic       mfc;
      out_t       exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset, start, MFC;
   logic [3:0]  opCode;
   logic [5:0]  para1, para2;
   logic [15:0] address;
   logic        marIn, MemEN, marOut, RW, readFromMem, outToBus;
   logic        readFromBus, outToMem, incr, fetch, busy, timeout_err;
   logic [5:0]  regIn, regOut;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   load_store_fsm_p #(
      .ADDR_W(16), .PARA_W(6), .NUM_REGS(6),
      .OP_LOAD(4'b1011), .OP_STORE(4'b1100), .MFC_TIMEOUT(4)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .opCode(opCode),
      .para1(para1), .para2(para2), .MFC(MFC), .address(address),
      .marIn(marIn), .MemEN(MemEN), .marOut(marOut), .RW(RW),
      .readFromMem(readFromMem), .outToBus(outToBus),
      .readFromBus(readFromBus), .outToMem(outToMem),
      .regIn(regIn), .regOut(regOut), .incr(incr), .fetch(fetch),
      .busy(busy), .timeout_err(timeout_err)
   );

   function automatic out_t mko(logic [11:0] c, logic [15:0] a,
                                logic [5:0] ri, logic [5:0] ro);
      out_t o;
      o.addr    = a;
      o.reg_in  = ri;
      o.reg_out = ro;
      o.ctrl    = c;
      return o;
   endfunction

   function automatic vec_t mkv(string n, logic r, logic s, logic [3:0] op,
                                logic [5:0] p1, logic [5:0] p2, logic m,
                                out_t e);
      vec_t v;
      v.name = n; v.rst = r; v.st = s; v.op = op;
      v.p1 = p1; v.p2 = p2; v.mfc = m; v.exp = e;
      return v;
   endfunction

   task automatic drive(logic r, logic s, logic [3:0] op, logic [5:0] p1,
                        logic [5:0] p2, logic m);
      reset = r; start = s; opCode = op; para1 = p1; para2 = p2; MFC = m;
   endtask

   task automatic check(string name, out_t exp);
      out_t act;
      act = mko({marIn, MemEN, marOut, RW, readFromMem, outToBus, readFromBus,
                 outToMem, incr, fetch, busy, timeout_err},
                address, regIn, regOut);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got addr=%h regIn=%b regOut=%b ctrl=%b, want addr=%h regIn=%b regOut=%b ctrl=%b",
                  name, act.addr, act.reg_in, act.reg_out, act.ctrl,
                  exp.addr, exp.reg_in, exp.reg_out, exp.ctrl);
      end else begin
         $display("[TB] ok   %s addr=%h regIn=%b regOut=%b ctrl=%b",
                  name, act.addr, act.reg_in, act.reg_out, act.ctrl);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   vec_t vecs[$];
   out_t Z;

   initial begin
      Z = '0;

      // ---------------- vector table ----------------
      // LOAD with MFC in the first MEM cycle. busy is high for exactly 4 rows.
      vecs.push_back(mkv("ld_idle",  0, 1, OPL, 6'd3, 6'h2A, 0, Z));
      vecs.push_back(mkv("ld_mar",   0, 0, OPL, 6'd3, 6'h2A, 1, mko(C_MARIN|C_BUSY, 16'h002A, 0, 0)));
      vecs.push_back(mkv("ld_mem",   0, 0, OPL, 6'd3, 6'h2A, 1, mko(C_MEMEN|C_MAROUT|C_RW|C_BUSY, 16'h002A, 0, 0)));
      vecs.push_back(mkv("ld_rdmem", 0, 0, OPL, 6'd3, 6'h2A, 0, mko(C_RDMEM|C_OUTBUS|C_BUSY, 16'h002A, 6'b001000, 0)));
      vecs.push_back(mkv("ld_done",  0, 0, OPL, 6'd3, 6'h2A, 0, mko(C_FETCH|C_INCR|C_BUSY, 16'h002A, 0, 0)));
      vecs.push_back(mkv("ld_back",  0, 0, OPL, 6'd3, 6'h2A, 0, Z));
      // STORE with MFC on the 3rd MEM cycle.
      vecs.push_back(mkv("st_idle",  0, 1, OPS, 6'd0, 6'h3F, 0, Z));
      vecs.push_back(mkv("st_mar",   0, 0, OPS, 6'd0, 6'h3F, 0, mko(C_MARIN|C_BUSY, 16'h003F, 0, 0)));
      vecs.push_back(mkv("st_bus",   0, 0, OPS, 6'd0, 6'h3F, 0, mko(C_RDBUS|C_BUSY, 16'h003F, 0, 6'b000001)));
      vecs.push_back(mkv("st_mem1",  0, 0, OPS, 6'd0, 6'h3F, 0, mko(C_MEMEN|C_MAROUT|C_OUTMEM|C_BUSY, 16'h003F, 0, 0)));
      vecs.push_back(mkv("st_mem2",  0, 0, OPS, 6'd0, 6'h3F, 0, mko(C_MEMEN|C_MAROUT|C_OUTMEM|C_BUSY, 16'h003F, 0, 0)));
      vecs.push_back(mkv("st_mem3",  0, 0, OPS, 6'd0, 6'h3F, 1, mko(C_MEMEN|C_MAROUT|C_OUTMEM|C_BUSY, 16'h003F, 0, 0)));
      vecs.push_back(mkv("st_done",  0, 0, OPS, 6'd0, 6'h3F, 0, mko(C_FETCH|C_INCR|C_BUSY, 16'h003F, 0, 0)));
      vecs.push_back(mkv("st_back",  0, 0, OPS, 6'd0, 6'h3F, 0, Z));
      // Illegal opcodes are ignored.
      vecs.push_back(mkv("ill_req",  0, 1, 4'b0000, 6'd1, 6'h11, 0, Z));
      vecs.push_back(mkv("ill_idle", 0, 1, 4'b1010, 6'd1, 6'h11, 0, Z));
      vecs.push_back(mkv("ill_idl2", 0, 0, 4'b0000, 6'd1, 6'h11, 0, Z));
      // LOAD with out-of-range para1=7. start pulses while busy are ignored.
      vecs.push_back(mkv("oob_idle", 0, 1, OPL, 6'd7, 6'h05, 0, Z));
      vecs.push_back(mkv("oob_mar",  0, 1, OPS, 6'd1, 6'h11, 0, mko(C_MARIN|C_BUSY, 16'h0005, 0, 0)));
      vecs.push_back(mkv("oob_mem",  0, 1, OPS, 6'd1, 6'h11, 1, mko(C_MEMEN|C_MAROUT|C_RW|C_BUSY, 16'h0005, 0, 0)));
      vecs.push_back(mkv("oob_rdm",  0, 1, OPL, 6'd2, 6'h12, 0, mko(C_RDMEM|C_OUTBUS|C_BUSY, 16'h0005, 0, 0)));
      vecs.push_back(mkv("oob_done", 0, 0, OPL, 6'd2, 6'h12, 0, mko(C_FETCH|C_INCR|C_BUSY, 16'h0005, 0, 0)));
      vecs.push_back(mkv("oob_back", 0, 0, OPL, 6'd2, 6'h12, 0, Z));
      vecs.push_back(mkv("oob_one",  0, 0, OPL, 6'd2, 6'h12, 0, Z));

      // ---------------- reset (overrides start) ----------------
      drive(1, 1, OPL, 6'd3, 6'h2A, 0);
      tick();
      check("rst_c1", Z);
      tick();
      check("rst_c2", Z);

      // ---------------- table loop ----------------
      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].st, vecs[i].op, vecs[i].p1, vecs[i].p2, vecs[i].mfc);
         check(vecs[i].name, vecs[i].exp);
         tick();
      end

      // ---------------- reset during MEM of a STORE ----------------
      drive(0, 1, OPS, 6'd4, 6'h07, 0);
      check("rm_idle", Z);
      tick();
      drive(0, 0, OPS, 6'd4, 6'h07, 0);
      check("rm_mar", mko(C_MARIN|C_BUSY, 16'h0007, 0, 0));
      tick();
      check("rm_bus", mko(C_RDBUS|C_BUSY, 16'h0007, 0, 6'b010000));
      tick();
      check("rm_mem", mko(C_MEMEN|C_MAROUT|C_OUTMEM|C_BUSY, 16'h0007, 0, 0));
      drive(1, 0, OPS, 6'd4, 6'h07, 1);
      tick();
      check("rm_abort", Z);
      drive(0, 0, OPS, 6'd4, 6'h07, 1);
      tick();
      check("rm_after1", Z);
      tick();
      check("rm_after2", Z);

`ifdef LSFSM_MFC_TIMEOUT_EN
      // ---------------- MFC timeout: MEM lasts exactly 4 cycles ----------------
      drive(0, 1, OPL, 6'd2, 6'h10, 0);
      check("to_idle", Z);
      tick();
      drive(0, 0, OPL, 6'd2, 6'h10, 0);
      check("to_mar", mko(C_MARIN|C_BUSY, 16'h0010, 0, 0));
      tick();
      for (int k = 1; k <= 4; k++) begin
         check($sformatf("to_mem%0d", k), mko(C_MEMEN|C_MAROUT|C_RW|C_BUSY, 16'h0010, 0, 0));
         tick();
      end
      check("to_err", mko(C_TERR|C_BUSY, 16'h0010, 0, 0));
      tick();
      check("to_back", Z);
      tick();
      check("to_quiet", Z);

      // MFC in the 4th MEM cycle wins over the expiring timeout.
      drive(0, 1, OPL, 6'd2, 6'h10, 0);
      check("tw_idle", Z);
      tick();
      drive(0, 0, OPL, 6'd2, 6'h10, 0);
      tick();
      for (int k = 1; k <= 4; k++) begin
         if (k == 4) MFC = 1'b1;
         check($sformatf("tw_mem%0d", k), mko(C_MEMEN|C_MAROUT|C_RW|C_BUSY, 16'h0010, 0, 0));
         tick();
      end
      MFC = 1'b0;
      check("tw_rdmem", mko(C_RDMEM|C_OUTBUS|C_BUSY, 16'h0010, 6'b000100, 0));
      tick();
      check("tw_done", mko(C_FETCH|C_INCR|C_BUSY, 16'h0010, 0, 0));
      tick();
      check("tw_back", Z);
`else
      // ---------------- no timeout: MEM waits well past MFC_TIMEOUT ----------------
      drive(0, 1, OPL, 6'd2, 6'h10, 0);
      check("nw_idle", Z);
      tick();
      drive(0, 0, OPL, 6'd2, 6'h10, 0);
      check("nw_mar", mko(C_MARIN|C_BUSY, 16'h0010, 0, 0));
      tick();
      for (int k = 1; k <= 12; k++) begin
         if (k == 12) MFC = 1'b1;
         check($sformatf("nw_mem%0d", k), mko(C_MEMEN|C_MAROUT|C_RW|C_BUSY, 16'h0010, 0, 0));
         tick();
      end
      MFC = 1'b0;
      check("nw_rdmem", mko(C_RDMEM|C_OUTBUS|C_BUSY, 16'h0010, 6'b000100, 0));
      tick();
      check("nw_done", mko(C_FETCH|C_INCR|C_BUSY, 16'h0010, 0, 0));
      tick();
      check("nw_back", Z);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Absolute time bound so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: got no finish by 100000, want finish earlier");
      $fatal(1, "watchdog expired");
   end

endmodule
